// File: rtl/apb_master_if.sv
// Command/response handshake and APB bus bundle for the apb_master requester.
// master: the requester's view; slave: the command source / APB completer side.
`timescale 1ns/1ps
interface apb_master_if #(
  parameter int unsigned AWD = 16,
  parameter int unsigned DWD = 32
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic           cmd_write;
  logic [AWD-1:0] cmd_addr;
  logic [DWD-1:0] cmd_wdata;

  logic           rsp_valid;
  logic           rsp_ready;
  logic [DWD-1:0] rsp_rdata;
  logic           rsp_err;
  logic           rsp_tmo;

  logic           psel;
  logic           penable;
  logic           pwrite;
  logic [AWD-1:0] paddr;
  logic [DWD-1:0] pwdata;
  logic [DWD-1:0] prdata;
  logic           pready;
  logic           pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS on APB,
// read data and error/timeout status returned on a valid/ready response.
`timescale 1ns/1ps
module apb_master #(
  parameter int unsigned AWD = 16,
  parameter int unsigned DWD = 32,
  parameter logic [7:0]  TMO = 8'd16
) (
  input  logic          pclk,
  input  logic          reset,
  apb_master_if.master  bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t         state, state_nxt;
  logic           accept;
  logic           tmo_hit;
  logic [7:0]     wait_cnt;
  logic [AWD-1:0] paddr_q;
  logic [DWD-1:0] pwdata_q;
  logic           pwrite_q;
  logic [DWD-1:0] rdata_q;
  logic           err_q;
  logic           tmo_q;
  logic           cmd_ready_c;
  logic           psel_c;
  logic           penable_c;
  logic           rsp_valid_c;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Handshake/bus controls decode from state only, so no input reaches an output.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    tmo_hit     = 1'b0;
    cmd_ready_c = 1'b0;
    psel_c      = 1'b0;
    penable_c   = 1'b0;
    rsp_valid_c = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        psel_c    = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel_c    = 1'b1;
        penable_c = 1'b1;
        if (bus.pready) begin
          state_nxt = RESP;
        end else if (TMO != 8'd0 && wait_cnt == TMO - 8'd1) begin
          tmo_hit   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      wait_cnt <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      if (accept) begin
        paddr_q  <= bus.cmd_addr;
        pwrite_q <= bus.cmd_write;
        pwdata_q <= bus.cmd_write ? bus.cmd_wdata : '0;
      end
      if (state == SETUP) wait_cnt <= '0;
      if (state == ACCESS) begin
        if (bus.pready) begin
          rdata_q <= (pwrite_q || bus.pslverr) ? '0 : bus.prdata;
          err_q   <= bus.pslverr;
          tmo_q   <= 1'b0;
        end else if (tmo_hit) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
          tmo_q   <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.psel      = psel_c;
  assign bus.penable   = penable_c;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_tmo   = tmo_q;

endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB requester that turns a valid/ready command stream into APB SETUP/ACCESS transfers, and returns read data and error status on a response handshake. It sits directly upstream of the APB slave stage and drives its psel/penable/paddr/pwrite/pwdata inputs. It consumes that stage's prdata/pready/pslverr outputs.

## Interface
- AWD, 16: address width.
- DWD, 32: data width.
- TMO, 8'd16: maximum ACCESS cycles allowed without pready; 0 disables the timeout.
- pclk  in  1  clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when both cmd_valid and cmd_ready are high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AWD  transfer address.
- cmd_wdata  in  DWD  write data (ignored for reads).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DWD  read data (0 for writes, error and timeout).
- rsp_err  out  1  pslverr sampled, or timeout.
- rsp_tmo  out  1  transfer aborted by timeout.
- psel, penable, pwrite  out  1 each  APB control.
- paddr  out  AWD  APB address.
- pwdata  out  DWD  APB write data.
- prdata  in  DWD  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.

## Operation
- States: IDLE, SETUP, ACCESS, RESP. All outputs are registered or decoded from the state only; no input-to-output combinational path.
- IDLE
  - cmd_ready=1.
  - On accept, latch cmd_write, cmd_addr and cmd_wdata into paddr, pwrite and pwdata, then go to SETUP.
  - For a read, pwdata is loaded with 0.
- SETUP: psel=1, penable=0; unconditionally go to ACCESS.
- ACCESS
  - psel=1, penable=1.
  - The wait counter (8-bit) clears on entry and increments each ACCESS cycle without pready.
  - If pready=1: capture rsp_rdata (prdata for reads, 0 for writes) and rsp_err=pslverr; set rsp_tmo=0; go to RESP.
  - Else if TMO!=0 and the counter equals TMO-1: rsp_rdata=0, rsp_err=1, rsp_tmo=1; go to RESP.
  - pready takes priority over timeout in the same cycle.
- RESP
  - psel=0, penable=0, rsp_valid=1.
  - Response fields are held stable until rsp_ready=1, then go to IDLE.
- paddr, pwrite and pwdata hold their last values outside a transfer. They never change between SETUP entry and ACCESS exit.
- Only one transfer is outstanding at a time. cmd_ready=0 in SETUP, ACCESS and RESP.
- Reset (any state, including mid-ACCESS):
  - State returns to IDLE.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_tmo and the counter all go to 0.
  - cmd_ready=1 after reset deasserts. The aborted transfer produces no response.

## Timing
- Command accepted at edge N:
  - Cycle N+1 is SETUP.
  - Cycle N+2 is the first ACCESS cycle.
  - With pready=1 in the first ACCESS cycle, rsp_valid rises in cycle N+3.
- Minimum cmd-accept to rsp_valid latency is 3 cycles. Each extra wait state adds 1 cycle.
- Timeout with TMO=16: 16 ACCESS cycles (N+2..N+17), then rsp_valid in N+18.
- With rsp_ready held high, RESP lasts 1 cycle, and cmd_ready=1 in the next cycle. Back-to-back command period is 4 cycles minimum.
- psel is low for at least the RESP and IDLE cycles between transfers; there is no SETUP-to-SETUP bursting.

## Test plan
- Write, zero wait: cmd_write=1, addr=16'h0010, wdata=32'hA5A5_0001; slave pready=1 in the first ACCESS cycle.
  - Required: one SETUP and one ACCESS cycle with paddr and pwdata stable.
  - rsp_valid at N+3 with rsp_err=0, rsp_tmo=0, rsp_rdata=0.
- Read, 2 wait states: addr=16'h0004; pready=1 in the third ACCESS cycle with prdata=32'hDEAD_BEEF.
  - Required: rsp_rdata=32'hDEAD_BEEF, rsp_valid at N+5.
- Slave error: read with pready=1 and pslverr=1.
  - Required: rsp_err=1, rsp_tmo=0.
- Timeout with TMO=16: pready held 0.
  - Required: exactly 16 penable cycles, then psel=0, rsp_err=1, rsp_tmo=1, rsp_rdata=0.
  - pready=1 on the 16th ACCESS cycle must instead give a normal response.
- Response backpressure: rsp_ready=0 for 5 cycles.
  - Required: rsp_valid and the response fields hold, cmd_ready stays 0.
  - A second queued command is accepted only in the cycle after rsp_ready=1.
- Reset during ACCESS.
  - Required: psel and penable are 0 immediately, with no response.
  - The next command completes normally with correct data.
